branch_sequencer: RTL



---
 rtl/cpu_ctrl_pkg.sv | 49 ++++
 rtl/branch_seq_outdec.sv | 34 +++
 rtl/branch_sequencer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared control-unit definitions: sequencer states, opcodes, C2 encodings,
// IR field positions and the datapath strobe bundle.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T3   = 3'd1,
        ST_T4   = 3'd2,
        ST_T5   = 3'd3,
        ST_T6   = 3'd4,
        ST_DONE = 3'd5
    } state_e;

    localparam int unsigned OPC_W = 5;
    localparam int unsigned RA_W  = 4;
    localparam int unsigned C2_W  = 2;

    localparam logic [OPC_W-1:0] OP_BR  = 5'b10010;
    localparam logic [OPC_W-1:0] OP_JR  = 5'b10100;
    localparam logic [OPC_W-1:0] OP_JAL = 5'b10011;

    localparam logic [C2_W-1:0] C2_ZERO    = 2'b00;
    localparam logic [C2_W-1:0] C2_NONZERO = 2'b01;
    localparam logic [C2_W-1:0] C2_GE_ZERO = 2'b10;
    localparam logic [C2_W-1:0] C2_LT_ZERO = 2'b11;

    localparam int unsigned IR_OPC_MSB = 31;
    localparam int unsigned IR_OPC_LSB = 27;
    localparam int unsigned IR_RA_MSB  = 26;
    localparam int unsigned IR_RA_LSB  = 23;
    localparam int unsigned IR_C2_MSB  = 20;
    localparam int unsigned IR_C2_LSB  = 19;
    localparam int unsigned IR_C_MSB   = 18;

    // Datapath strobes decoded from state; pc_in_en is qualified by the condition later.
    typedef struct packed {
        logic gra;
        logic rout;
        logic con_in;
        logic pc_out;
        logic y_in;
        logic c_out;
        logic alu_add;
        logic z_in;
        logic zlow_out;
        logic pc_in_en;
    } strobe_t;

endpackage

// File: rtl/branch_seq_outdec.sv
// Pure combinational state-to-strobe decoder, shared with the jump sequencers.
module branch_seq_outdec
    import cpu_ctrl_pkg::*;
(
    input  state_e  state_i,
    output strobe_t strobe_o
);

    always_comb begin
        strobe_o = '0;
        case (state_i)
            ST_T3: begin
                strobe_o.gra    = 1'b1;
                strobe_o.rout   = 1'b1;
                strobe_o.con_in = 1'b1;
            end
            ST_T4: begin
                strobe_o.pc_out = 1'b1;
                strobe_o.y_in   = 1'b1;
            end
            ST_T5: begin
                strobe_o.c_out   = 1'b1;
                strobe_o.alu_add = 1'b1;
                strobe_o.z_in    = 1'b1;
            end
            ST_T6: begin
                strobe_o.zlow_out = 1'b1;
                strobe_o.pc_in_en = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/branch_sequencer.sv
// Moore sequencer for the conditional-branch datapath: T3 condition, T4 PC->Y,
// T5 PC+C->Z, T6 Z->PC gated by the condition flip-flop.
module branch_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter bit SKIP_ON_FALSE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] ir,
    input  logic        con_q,
    output logic        busy,
    output logic        done,
    output logic        taken,
    output logic        illegal,
    output logic        gra,
    output logic        rout,
    output logic        con_in,
    output logic [1:0]  con_bits,
    output logic        pc_out,
    output logic        y_in,
    output logic        c_out,
    output logic        alu_add,
    output logic        z_in,
    output logic        zlow_out,
    output logic        pc_in
);

    state_e             state_q, state_d;
    logic [OPC_W-1:0]   opc_q, opc_d;
    logic [RA_W-1:0]    ra_q, ra_d;
    logic [C2_W-1:0]    c2_q, c2_d;
    logic               taken_q, taken_d;
    logic               illegal_q, illegal_d;
    strobe_t            strobe;
    logic               active;

    // Ra and the offset are consumed by the register file and C-extender, not here.
    logic unused_fields;
    assign unused_fields = ^{ir[22:21], ir[IR_C_MSB:0], ra_q, opc_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            opc_q     <= '0;
            ra_q      <= '0;
            c2_q      <= '0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opc_q     <= opc_d;
            ra_q      <= ra_d;
            c2_q      <= c2_d;
            taken_q   <= taken_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        opc_d     = opc_q;
        ra_d      = ra_q;
        c2_d      = c2_q;
        taken_d   = taken_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    opc_d   = ir[IR_OPC_MSB:IR_OPC_LSB];
                    ra_d    = ir[IR_RA_MSB:IR_RA_LSB];
                    c2_d    = ir[IR_C2_MSB:IR_C2_LSB];
                    taken_d = 1'b0;
                    if (ir[IR_OPC_MSB:IR_OPC_LSB] == OP_BR) begin
                        illegal_d = 1'b0;
                        state_d   = ST_T3;
                    end else begin
                        illegal_d = 1'b1;
                        state_d   = ST_DONE;
                    end
                end
            end
            ST_T3: state_d = ST_T4;
            ST_T4: begin
                // con_q was loaded at the T3 edge and is stable here.
                taken_d = con_q;
                state_d = (SKIP_ON_FALSE && !con_q) ? ST_DONE : ST_T5;
            end
            ST_T5:   state_d = ST_T6;
            ST_T6:   state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    branch_seq_outdec u_outdec (
        .state_i  (state_q),
        .strobe_o (strobe)
    );

    // Outputs are held low in any cycle where reset is asserted.
    assign active   = (state_q != ST_IDLE) && !reset;
    assign busy     = active;
    assign done     = active && (state_q == ST_DONE);
    assign taken    = done && taken_q;
    assign illegal  = done && illegal_q;
    assign con_bits = active ? c2_q : 2'b00;
    assign gra      = active && strobe.gra;
    assign rout     = active && strobe.rout;
    assign con_in   = active && strobe.con_in;
    assign pc_out   = active && strobe.pc_out;
    assign y_in     = active && strobe.y_in;
    assign c_out    = active && strobe.c_out;
    assign alu_add  = active && strobe.alu_add;
    assign z_in     = active && strobe.z_in;
    assign zlow_out = active && strobe.zlow_out;
    assign pc_in    = active && strobe.pc_in_en && taken_q;

endmodule
